mpu_add_seq: RTL and testbench

Row-serial sequencer for the MPU element-wise matrix adder. Loads two DIM×DIM unsigned matrices row by row over a valid/ready input stream, computes the element-wise sum one row per cycle into an internal result buffer, then streams the result rows out over a valid/ready output stream. Sits between the MPU command/data front end and downstream consumers, so the bus carries one row (DIM elements) per beat instead of a full flattened matrix.

---
 rtl/mpu_add_seq.sv | 164 ++++++++++++++++
 tb/tb_mpu_add_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_add_seq.sv
// Row-serial element-wise adder for two DIMxDIM unsigned matrices: load A, load B, add a row per cycle, stream results.
// Optional build macro MPU_ADD_SAT_EN selects saturating sums; the default build wraps modulo 2^WIDTH.
module mpu_add_seq #(
    parameter int DIM   = 5,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH*DIM-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH*DIM-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(DIM - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_A  = 3'd1;
    localparam logic [2:0] S_LOAD_B  = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_STREAM  = 3'd4;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_overflow;
    logic                 w_overflow_nxt;

    logic [WIDTH*DIM-1:0] r_a [DIM];
    logic [WIDTH*DIM-1:0] r_b [DIM];
    logic [WIDTH*DIM-1:0] r_r [DIM];

    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_row_last;
    logic [WIDTH*DIM-1:0] w_a_row;
    logic [WIDTH*DIM-1:0] w_b_row;
    logic [WIDTH*DIM-1:0] w_row_sum;
    logic                 w_row_carry;
    logic [WIDTH:0]       w_elem;

    // Handshake: a row moves on a rising edge where valid and ready are both high.
    // in_ready and out_valid depend only on registered state, never on the partner's signal.
    assign in_ready   = (r_state == S_LOAD_A) || (r_state == S_LOAD_B);
    assign out_valid  = (r_state == S_STREAM);
    assign out_data   = (r_state == S_STREAM) ? r_r[r_cnt] : '0;
    assign out_last   = (r_state == S_STREAM) && (r_cnt == LAST_ROW);
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign overflow   = r_overflow;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_row_last = (r_cnt == LAST_ROW);
    assign w_a_row    = r_a[r_cnt];
    assign w_b_row    = r_b[r_cnt];

    always_comb begin
        w_row_sum   = '0;
        w_row_carry = 1'b0;
        w_elem      = '0;
        for (int c = 0; c < DIM; c++) begin
            w_elem      = {1'b0, w_a_row[WIDTH*c +: WIDTH]} + {1'b0, w_b_row[WIDTH*c +: WIDTH]};
            w_row_carry = w_row_carry | w_elem[WIDTH];
`ifdef MPU_ADD_SAT_EN
            w_row_sum[WIDTH*c +: WIDTH] = w_elem[WIDTH] ? {WIDTH{1'b1}} : w_elem[WIDTH-1:0];
`else
            w_row_sum[WIDTH*c +: WIDTH] = w_elem[WIDTH-1:0];
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_done_nxt     = 1'b0;
        w_overflow_nxt = r_overflow;
        if (abort) begin
            // abort beats everything, including a simultaneous start in IDLE
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_state_nxt    = S_LOAD_A;
                        w_cnt_nxt      = '0;
                        w_overflow_nxt = 1'b0;
                    end
                end
                S_LOAD_A: begin
                    if (w_in_fire) begin
                        w_state_nxt = w_row_last ? S_LOAD_B : S_LOAD_A;
                        w_cnt_nxt   = w_row_last ? '0 : r_cnt + 1'b1;
                    end
                end
                S_LOAD_B: begin
                    if (w_in_fire) begin
                        w_state_nxt = w_row_last ? S_COMPUTE : S_LOAD_B;
                        w_cnt_nxt   = w_row_last ? '0 : r_cnt + 1'b1;
                    end
                end
                S_COMPUTE: begin
                    w_overflow_nxt = r_overflow | w_row_carry;
                    w_state_nxt    = w_row_last ? S_STREAM : S_COMPUTE;
                    w_cnt_nxt      = w_row_last ? '0 : r_cnt + 1'b1;
                end
                S_STREAM: begin
                    if (w_out_fire) begin
                        w_state_nxt = w_row_last ? S_IDLE : S_STREAM;
                        w_cnt_nxt   = w_row_last ? '0 : r_cnt + 1'b1;
                        w_done_nxt  = w_row_last;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_done     <= w_done_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Row buffers hold no reset; their contents are only visible through STREAM.
    always_ff @(posedge clk) begin
        if (!abort) begin
            if (r_state == S_LOAD_A && w_in_fire) begin
                r_a[r_cnt] <= in_data;
            end
            if (r_state == S_LOAD_B && w_in_fire) begin
                r_b[r_cnt] <= in_data;
            end
            if (r_state == S_COMPUTE) begin
                r_r[r_cnt] <= w_row_sum;
            end
        end
    end

endmodule

// File: tb/tb_mpu_add_seq.sv
// Directed bench for mpu_add_seq: scoreboard queue of expected result rows, negedge output monitor.
module tb_mpu_add_seq;

    localparam int DIM   = 5;
    localparam int WIDTH = 8;
    localparam int RW    = WIDTH * DIM;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [RW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          overflow;

    always #5 clk = ~clk;

    mpu_add_seq #(.DIM(DIM), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    int            checks = 0;
    int            failures = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] mat_a [DIM];
    logic [RW-1:0] mat_b [DIM];
    bit            exp_ovf = 1'b0;
    int            cyc = 0;
    int            start_cyc = 0;
    int            done_cyc = 0;
    int            done_cnt = 0;
    int            mon_row = 0;
    bit            held_v = 1'b0;
    logic [RW-1:0] held_d = '0;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: data must hold while stalled; accepted rows pop the scoreboard in order.
    always @(negedge clk) begin
        if (!rst_n || !busy) begin
            mon_row = 0;
            held_v  = 1'b0;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (out_valid) begin
            if (held_v) check("out_hold", out_data, held_d);
            if (out_ready) begin
                check("out_last", RW'(out_last), RW'(mon_row == DIM - 1));
                check("row_avail", RW'(exp_q.size() != 0), RW'(1));
                if (exp_q.size() != 0) check("out_row", out_data, exp_q.pop_front());
                mon_row++;
                held_v = 1'b0;
            end else begin
                held_d = out_data;
                held_v = 1'b1;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input logic [RW-1:0] a, input logic [RW-1:0] b);
        logic [RW-1:0] row;
        int s;
        row = '0;
        for (int c = 0; c < DIM; c++) begin
            s = int'(a[WIDTH*c +: WIDTH]) + int'(b[WIDTH*c +: WIDTH]);
            if (s >= 2**WIDTH) begin
                exp_ovf = 1'b1;
`ifdef MPU_ADD_SAT_EN
                s = 2**WIDTH - 1;
`else
                s = s - 2**WIDTH;
`endif
            end
            row[WIDTH*c +: WIDTH] = WIDTH'(s);
        end
        exp_q.push_back(row);
    endtask

    task automatic send_row(input logic [RW-1:0] d, input bit gaps, input bit pulse_start);
        int n;
        bit ok;
        n = 0;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1 && n < 4) begin
                in_valid = 1'b0;
                tick();
                n++;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        start    = pulse_start;
        n = 0;
        do begin
            ok = in_ready;
            tick();
            start = 1'b0;
            n++;
        end while (!ok && n < 50);
        in_valid = 1'b0;
        check("in_accept", RW'(ok), RW'(1));
    endtask

    task automatic load(input int nb, input bit gaps, input int start_row);
        for (int r = 0; r < DIM; r++) send_row(mat_a[r], gaps, 1'b0);
        for (int r = 0; r < nb; r++) begin
            push_row(mat_a[r], mat_b[r]);
            send_row(mat_b[r], gaps, r == start_row);
        end
    endtask

    task automatic begin_op();
        exp_ovf = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        start_cyc = cyc;
        check("busy_after_start", RW'(busy), RW'(1));
        check("in_ready_after_start", RW'(in_ready), RW'(1));
        check("overflow_cleared", RW'(overflow), RW'(0));
    endtask

    task automatic finish_op(input bit rand_ready, input int start_tick, input int exp_cycles);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            out_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            start = (n == start_tick);
            tick();
            start = 1'b0;
            n++;
        end
        out_ready = 1'b0;
        tick();
        tick();
        check("done_once", RW'(done_cnt - d0), RW'(1));
        check("idle_after_done", RW'(busy), RW'(0));
        check("queue_drained", RW'(exp_q.size()), RW'(0));
        check("overflow_flag", RW'(overflow), RW'(exp_ovf));
        if (exp_cycles > 0) check("start_to_done", RW'(done_cyc - start_cyc), RW'(exp_cycles));
    endtask

    task automatic fill_ramp();
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                mat_a[r][WIDTH*c +: WIDTH] = WIDTH'(DIM * r + c + 1);
                mat_b[r][WIDTH*c +: WIDTH] = WIDTH'(DIM * DIM - (DIM * r + c));
            end
        end
    endtask

    task automatic fill_const(input int va, input int vb);
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                mat_a[r][WIDTH*c +: WIDTH] = WIDTH'(va);
                mat_b[r][WIDTH*c +: WIDTH] = WIDTH'(vb);
            end
        end
    endtask

    task automatic fill_ident3();
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                mat_a[r][WIDTH*c +: WIDTH] = (r == c) ? WIDTH'(3) : WIDTH'(0);
                mat_b[r][WIDTH*c +: WIDTH] = (r == c) ? WIDTH'(3) : WIDTH'(0);
            end
        end
    endtask

    initial begin
        int n;
        int d0;
        logic [RW-1:0] all26;
        logic [RW-1:0] row_id;

        // reset state
        repeat (2) tick();
        check("rst_in_ready", RW'(in_ready), RW'(0));
        check("rst_out_valid", RW'(out_valid), RW'(0));
        check("rst_out_data", out_data, RW'(0));
        check("rst_busy", RW'(busy), RW'(0));
        check("rst_done", RW'(done), RW'(0));
        check("rst_overflow", RW'(overflow), RW'(0));
        rst_n = 1'b1;
        tick();

        // ramp: every sum is 26; no stalls, 20 edges after the start edge (21 cycles incl. start)
        fill_ramp();
        all26 = '0;
        for (int c = 0; c < DIM; c++) all26[WIDTH*c +: WIDTH] = WIDTH'(26);
        for (int r = 0; r < DIM; r++) begin
            row_id = mat_a[r];
            check("ramp_pair_sum", RW'(int'(row_id[7:0]) + int'(mat_b[r][7:0])), RW'(26));
        end
        begin_op();
        out_ready = 1'b1;
        load(DIM, 1'b0, -1);
        check("ramp_model_row0", exp_q[0], all26);
        finish_op(1'b0, 7, 4 * DIM);

        // carry out: 200 + 100 wraps to 44 or saturates to 255
        fill_const(200, 100);
        begin_op();
        load(DIM, 1'b0, -1);
`ifdef MPU_ADD_SAT_EN
        check("big_model_elem", RW'(exp_q[0][7:0]), RW'(255));
`else
        check("big_model_elem", RW'(exp_q[0][7:0]), RW'(44));
`endif
        finish_op(1'b0, -1, 0);
        check("overflow_sticky", RW'(overflow), RW'(1));

        // identity*3 with input gaps, random output stalls, start pulsed during LOAD_B
        fill_ident3();
        begin_op();
        load(DIM, 1'b1, 2);
        finish_op(1'b1, -1, 0);

        // abort after two B rows
        fill_ramp();
        begin_op();
        load(2, 1'b0, -1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", RW'(busy), RW'(0));
        check("abort_in_ready", RW'(in_ready), RW'(0));
        check("abort_out_valid", RW'(out_valid), RW'(0));
        exp_q.delete();
        d0 = done_cnt;
        out_ready = 1'b1;
        repeat (10) tick();
        out_ready = 1'b0;
        check("abort_no_done", RW'(done_cnt - d0), RW'(0));
        begin_op();
        load(DIM, 1'b0, -1);
        finish_op(1'b0, -1, 0);

        // asynchronous reset in STREAM at row 2
        begin_op();
        load(DIM, 1'b0, -1);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("stream_reached", RW'(out_valid), RW'(1));
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        check("stream_row2_not_last", RW'(out_last), RW'(0));
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", RW'(out_valid), RW'(0));
        check("mid_rst_out_data", out_data, RW'(0));
        check("mid_rst_busy", RW'(busy), RW'(0));
        check("mid_rst_in_ready", RW'(in_ready), RW'(0));
        check("mid_rst_overflow", RW'(overflow), RW'(0));
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        fill_ident3();
        begin_op();
        load(DIM, 1'b0, -1);
        finish_op(1'b1, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
